down_counter_timer: RTL

//  Synchronous loadable down-counter/timer; the counting-down counterpart of our ripple up-counter.

---
 rtl/down_counter_timer.sv | 115 +++++++++++
 1 files changed

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts a loaded value down to zero once per tick, then stops or reloads.
// Latency: one cycle from load/tick to q, tc and busy (all registered); zero is combinational from q.
// Backpressure: none; en low holds the count (and the prescaler with DOWN_CNT_PRESCALE_EN defined).
module down_counter_timer #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  en,
    input  logic                  auto_reload,
`ifdef DOWN_CNT_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] presc_div,
`endif
    output logic [WIDTH-1:0]      q,
    output logic                  zero,
    output logic                  tc,
    output logic                  busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] reload_reg, reload_n;
    logic             tc_n;
    logic             tick;

`ifdef DOWN_CNT_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescaler, prescaler_n;

    // Prescaler counts enabled COUNT cycles 0..presc_div; a tick fires on the wrap.
    always_comb begin
        prescaler_n = prescaler;
        tick        = 1'b0;
        if (load) begin
            prescaler_n = '0;
        end else if (en && state == COUNT) begin
            if (prescaler == presc_div) begin
                prescaler_n = '0;
                tick        = 1'b1;
            end else begin
                prescaler_n = prescaler + PRESCALE_W'(1);
            end
        end
    end

    // Prescaler register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler_n;
        end
    end
`else
    // Without the prescaler every enabled cycle in COUNT is a tick.
    always_comb begin
        tick = en && (state == COUNT);
    end
`endif

    // Next-state logic: load beats tick; q==1 ends a period, q==0 (periodic only) reloads.
    always_comb begin
        state_n  = state;
        q_n      = q;
        reload_n = reload_reg;
        tc_n     = 1'b0;
        if (load) begin
            q_n      = load_val;
            reload_n = load_val;
            state_n  = (load_val != '0) ? COUNT : IDLE;
        end else if (tick) begin
            if (q > WIDTH'(1)) begin
                q_n = q - WIDTH'(1);
            end else if (q == WIDTH'(1)) begin
                q_n  = '0;
                tc_n = 1'b1;
                if (!auto_reload) begin
                    state_n = IDLE;
                end
            end else begin
                // q==0 while still in COUNT only happens in periodic mode.
                q_n = reload_reg;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            q          <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else begin
            state      <= state_n;
            q          <= q_n;
            reload_reg <= reload_n;
            tc         <= tc_n;
        end
    end

    // Status outputs derived from the registered state and count.
    always_comb begin
        zero = (q == '0);
        busy = (state == COUNT);
    end

endmodule
